lift_controller: RTL and testbench

Request scheduler and car sequencer for the lift. Latches floor-call requests into a pending bitmap, then steps the car floor by floor using a travel timer and holds the door for a fixed dwell. It keeps serving calls in the current direction before reversing, so calls are served in an elevator-style sweep. It sits above the per-floor lift FSM and drives car position, direction and door outputs for the rest of the design.

---
 rtl/lift_controller_if.sv | 37 +++
 rtl/lift_controller.sv | 182 ++++++++++++++++++
 tb/tb_lift_controller.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lift_controller_if.sv
// rtl/lift_controller_if.sv - call/status bundle between the lift controller and its user
//
// Signals:
//   req          floor-call requests, bit i = call to floor i (level)
//   floor        current car floor
//   door_open    door held open at the current floor
//   moving_up    car travelling upwards
//   moving_down  car travelling downwards
//   pending      outstanding-call bitmap
//   busy         controller has work in progress or outstanding calls
//
// Modports:
//   master  drives calls, observes car status (the user side)
//   slave   receives calls, drives car status (the controller side)

interface lift_controller_if #(
    parameter int FLOORS  = 4,
    parameter int FLOOR_W = 2
);
    logic [FLOORS-1:0]  req;
    logic [FLOOR_W-1:0] floor;
    logic               door_open;
    logic               moving_up;
    logic               moving_down;
    logic [FLOORS-1:0]  pending;
    logic               busy;

    modport master (
        output req,
        input  floor, door_open, moving_up, moving_down, pending, busy
    );

    modport slave (
        input  req,
        output floor, door_open, moving_up, moving_down, pending, busy
    );
endinterface

// File: rtl/lift_controller.sv
// rtl/lift_controller.sv - floor-call scheduler and car sequencer with sweep ordering
//
// Latches floor calls into a pending bitmap, steps the car one floor per
// TRAVEL_CYCLES and holds the door for DOOR_CYCLES. Calls in the current
// travel direction are served before the car reverses.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    lift_controller_if.slave: req in; floor, door_open, moving_up,
//          moving_down, pending, busy out

module lift_controller #(
    parameter int FLOORS        = 4,
    parameter int FLOOR_W       = 2,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input  logic               clk,
    input  logic               reset,
    lift_controller_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;
    localparam logic [1:0] ST_DOOR = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Timers count down from CYCLES-1 to 0, so they only need clog2(CYCLES) bits.
    localparam int TRAVEL_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DOOR_W   = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    localparam logic [TRAVEL_W-1:0] TRAVEL_LOAD = TRAVEL_W'(TRAVEL_CYCLES - 1);
    localparam logic [DOOR_W-1:0]   DOOR_LOAD   = DOOR_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0]  TOP_FLOOR   = FLOOR_W'(FLOORS - 1);
    localparam logic [FLOORS-1:0]   BIT0        = FLOORS'(1);

    logic [1:0]          state_q,   state_d;
    logic [FLOOR_W-1:0]  floor_q,   floor_d;
    logic                dir_q,     dir_d;
    logic [TRAVEL_W-1:0] travel_q,  travel_d;
    logic [DOOR_W-1:0]   door_q,    door_d;
    logic [FLOORS-1:0]   pending_q, pending_d;

    logic [FLOORS-1:0]   clear_mask;
    logic [FLOORS-1:0]   hold_mask;
    logic [FLOOR_W-1:0]  arrive_floor;
    logic                up_here, down_here;
    logic                up_there, down_there;
    logic                go_up, go_down;

    function automatic logic calls_above(input logic [FLOORS-1:0] p,
                                         input logic [FLOOR_W-1:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i > int'(f) && p[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    function automatic logic calls_below(input logic [FLOORS-1:0] p,
                                         input logic [FLOOR_W-1:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i < int'(f) && p[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Floor the car reaches when the travel timer expires.
    assign arrive_floor = (state_q == ST_DOWN) ? floor_q - FLOOR_W'(1)
                                               : floor_q + FLOOR_W'(1);

    assign up_here    = calls_above(pending_q, floor_q);
    assign down_here  = calls_below(pending_q, floor_q);
    assign up_there   = calls_above(pending_q, arrive_floor);
    assign down_there = calls_below(pending_q, arrive_floor);

    // Keep going the way we last went; reverse only when nothing lies ahead.
    assign go_up   = (dir_q == DIR_UP) ? up_here : (up_here && !down_here);
    assign go_down = (dir_q == DIR_UP) ? (down_here && !up_here) : down_here;

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        travel_d   = travel_q;
        door_d     = door_q;
        clear_mask = '0;
        hold_mask  = '0;

        case (state_q)
            ST_IDLE: begin
                if (pending_q[floor_q]) begin
                    state_d    = ST_DOOR;
                    door_d     = DOOR_LOAD;
                    clear_mask = BIT0 << floor_q;
                end else if (go_up) begin
                    state_d  = ST_UP;
                    dir_d    = DIR_UP;
                    travel_d = TRAVEL_LOAD;
                end else if (go_down) begin
                    state_d  = ST_DOWN;
                    dir_d    = DIR_DOWN;
                    travel_d = TRAVEL_LOAD;
                end
            end

            ST_UP, ST_DOWN: begin
                if (travel_q == '0) begin
                    floor_d = arrive_floor;
                    if (pending_q[arrive_floor]) begin
                        // Door opens on the same edge as the final floor step.
                        state_d    = ST_DOOR;
                        door_d     = DOOR_LOAD;
                        clear_mask = BIT0 << arrive_floor;
                    end else if ((state_q == ST_UP) ? up_there : down_there) begin
                        travel_d = TRAVEL_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    travel_d = travel_q - TRAVEL_W'(1);
                end
            end

            default: begin // ST_DOOR
                // A call to the open floor keeps the door open instead of queueing.
                hold_mask = BIT0 << floor_q;
                if (bus.req[floor_q]) begin
                    door_d = DOOR_LOAD;
                end else if (door_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    door_d = door_q - DOOR_W'(1);
                end
            end
        endcase

        pending_d = (pending_q | (bus.req & ~hold_mask)) & ~clear_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            floor_q   <= '0;
            dir_q     <= DIR_UP;
            travel_q  <= '0;
            door_q    <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            travel_q  <= travel_d;
            door_q    <= door_d;
            pending_q <= pending_d;
        end
    end

    assign bus.floor       = floor_q;
    assign bus.door_open   = (state_q == ST_DOOR);
    assign bus.moving_up   = (state_q == ST_UP);
    assign bus.moving_down = (state_q == ST_DOWN);
    assign bus.pending     = pending_q;
    assign bus.busy        = (state_q != ST_IDLE) || (pending_q != '0);

`ifndef SYNTHESIS
    floor_in_range: assert property (@(posedge clk) disable iff (reset)
                                     floor_q <= TOP_FLOOR);
`endif

endmodule

// File: tb/tb_lift_controller.sv
// tb/tb_lift_controller.sv - self-checking bench for lift_controller

module tb_lift_controller;

    localparam int FLOORS  = 4;
    localparam int FLOOR_W = 2;
    localparam int T       = 8;
    localparam int D       = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    lift_controller_if #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) bus ();

    lift_controller #(
        .FLOORS        (FLOORS),
        .FLOOR_W       (FLOOR_W),
        .TRAVEL_CYCLES (T),
        .DOOR_CYCLES   (D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Abstract car model: position and last travel direction (0 up, 1 down).
    int model_pos;
    int model_dir;
    int exp_f[$];
    int exp_t[$];

    typedef struct {
        logic [3:0] req;
        int         n;
        logic [1:0] floor;
        logic       door;
        logic       up;
        logic       down;
        logic [3:0] pend;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int outputs_word();
        return int'({bus.floor, bus.door_open, bus.moving_up, bus.moving_down, bus.pending});
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        bus.req = '0;
        @(negedge clk);
        reset     = 1'b0;
        model_pos = 0;
        model_dir = 0;
    endtask

    // Caller sits at a negedge; req is high for exactly one rising edge.
    task automatic pulse(input logic [3:0] r);
        bus.req = r;
        @(posedge clk);
        @(negedge clk);
        bus.req = '0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(n < budget), 1);
    endtask

    // Predicts door-open floor and edge index (edge 0 samples the call) from
    // the sweep rule: serve here, else nearest call ahead, else reverse.
    task automatic build_schedule(input int bits);
        int pend, t, go, target, k;
        logic has_up, has_dn;
        exp_f.delete();
        exp_t.delete();
        pend = bits;
        t    = 1;
        while (pend != 0) begin
            if ((pend & (1 << model_pos)) != 0) begin
                exp_f.push_back(model_pos);
                exp_t.push_back(t);
                pend = pend & ~(1 << model_pos);
                t    = t + D + 1;
            end else begin
                has_up = (pend >> (model_pos + 1)) != 0;
                has_dn = (pend & ((1 << model_pos) - 1)) != 0;
                if (model_dir == 0) go = has_up ? 1 : -1;
                else                go = has_dn ? -1 : 1;
                target = model_pos + go;
                while ((pend & (1 << target)) == 0) target = target + go;
                k = (target > model_pos) ? target - model_pos : model_pos - target;
                t = t + k * T;
                exp_f.push_back(target);
                exp_t.push_back(t);
                model_dir = (go > 0) ? 0 : 1;
                model_pos = target;
                pend      = pend & ~(1 << target);
                t         = t + D + 1;
            end
        end
    endtask

    initial begin
        int got_f[$];
        int got_t[$];
        int door_floors[$];
        int e, n, bad, word;
        logic prev;
        logic [3:0] p;

        bus.req = '0;

        // ---------------- reset behaviour ----------------
        @(negedge clk);
        check("reset_outputs", outputs_word() | int'(bus.busy), 0);
        reset = 1'b0;
        model_pos = 0;
        model_dir = 0;
        repeat (5) @(negedge clk);
        check("idle_stays_idle", int'(bus.busy), 0);

        pulse(4'b1000);
        repeat (12) @(negedge clk);
        check("pre_reset_moving", int'({bus.floor, bus.moving_up}), 3);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs", outputs_word() | int'(bus.busy), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("after_reset_idle", int'({bus.busy, bus.floor}), 0);

        // ---------------- table-driven vectors from reset ----------------
        vecs[0]  = '{4'b0001,  0, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0001};
        vecs[1]  = '{4'b0001,  1, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000};
        vecs[2]  = '{4'b0001, 16, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000};
        vecs[3]  = '{4'b0001, 17, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[4]  = '{4'b1000,  1, 2'd0, 1'b0, 1'b1, 1'b0, 4'b1000};
        vecs[5]  = '{4'b1000,  8, 2'd0, 1'b0, 1'b1, 1'b0, 4'b1000};
        vecs[6]  = '{4'b1000,  9, 2'd1, 1'b0, 1'b1, 1'b0, 4'b1000};
        vecs[7]  = '{4'b1000, 24, 2'd2, 1'b0, 1'b1, 1'b0, 4'b1000};
        vecs[8]  = '{4'b1000, 25, 2'd3, 1'b1, 1'b0, 1'b0, 4'b0000};
        vecs[9]  = '{4'b1000, 40, 2'd3, 1'b1, 1'b0, 1'b0, 4'b0000};
        vecs[10] = '{4'b1000, 41, 2'd3, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[11] = '{4'b1001,  1, 2'd0, 1'b1, 1'b0, 1'b0, 4'b1000};
        vecs[12] = '{4'b1001, 18, 2'd0, 1'b0, 1'b1, 1'b0, 4'b1000};
        vecs[13] = '{4'b0100, 17, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000};
        vecs[14] = '{4'b0010,  0, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0010};

        for (int i = 0; i < 15; i++) begin
            do_reset();
            pulse(vecs[i].req);
            repeat (vecs[i].n) @(negedge clk);
            word = int'({vecs[i].floor, vecs[i].door, vecs[i].up, vecs[i].down, vecs[i].pend});
            check($sformatf("vec%0d", i), outputs_word(), word);
        end

        // ---------------- sweep order 2, 3, 0 ----------------
        do_reset();
        pulse(4'b0010);
        wait_idle("sweep_setup_idle", 100);
        check("sweep_setup_floor", int'(bus.floor), 1);
        pulse(4'b1000);
        repeat (3) @(negedge clk);
        pulse(4'b0101);
        door_floors.delete();
        prev = 1'b0;
        n = 0;
        while (bus.busy && n < 400) begin
            if (bus.door_open && !prev) door_floors.push_back(int'(bus.floor));
            prev = bus.door_open;
            @(negedge clk);
            n++;
        end
        check("sweep_done", int'(n < 400), 1);
        check("sweep_count", door_floors.size(), 3);
        if (door_floors.size() == 3) begin
            check("sweep_first", door_floors[0], 2);
            check("sweep_second", door_floors[1], 3);
            check("sweep_third", door_floors[2], 0);
        end

        // ---------------- door hold ----------------
        pulse(4'b0100);
        n = 0;
        while (!bus.door_open && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_door_reached", int'({bus.door_open, bus.floor}), 6);
        bus.req = 4'b0100;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.door_open || bus.pending[2]) bad++;
        end
        bus.req = '0;
        check("hold_door_steady", bad, 0);
        n = 0;
        while (bus.door_open && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("hold_close_delay", n, D);
        check("hold_pending_clear", int'(bus.pending), 0);

        // ---------------- reset mid-travel ----------------
        do_reset();
        pulse(4'b1000);
        wait_idle("midtravel_setup", 100);
        pulse(4'b0011);
        repeat (4) @(negedge clk);
        check("midtravel_state", int'({bus.moving_down, bus.floor, bus.pending}), 'h7_3);
        #2 reset = 1'b1;
        #1;
        check("midtravel_reset", outputs_word() | int'(bus.busy), 0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.door_open || bus.busy) bad++;
        end
        check("midtravel_quiet", bad, 0);
        model_pos = 0;
        model_dir = 0;

        // ---------------- randomized batches vs sweep model ----------------
        for (int b = 0; b < 30; b++) begin
            p = 4'($urandom_range(1, 15));
            build_schedule(int'(p));
            got_f.delete();
            got_t.delete();
            bus.req = p;
            @(posedge clk);
            @(negedge clk);
            bus.req = '0;
            e    = 0;
            prev = 1'b0;
            bad  = 0;
            while (e < 400) begin
                if (bus.door_open && !prev) begin
                    got_f.push_back(int'(bus.floor));
                    got_t.push_back(e);
                end
                if (int'(bus.door_open) + int'(bus.moving_up) + int'(bus.moving_down) > 1) bad++;
                prev = bus.door_open;
                if (!bus.busy) break;
                @(negedge clk);
                e++;
            end
            check($sformatf("rand%0d_done", b), int'(e < 400), 1);
            check($sformatf("rand%0d_excl", b), bad, 0);
            check($sformatf("rand%0d_count", b), got_f.size(), exp_f.size());
            for (int i = 0; i < got_f.size() && i < exp_f.size(); i++) begin
                check($sformatf("rand%0d_floor%0d", b, i), got_f[i], exp_f[i]);
                check($sformatf("rand%0d_time%0d", b, i), got_t[i], exp_t[i]);
            end
            check($sformatf("rand%0d_final", b), int'(bus.floor), model_pos);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
